mvp_sequencer: RTL

- Sequences the shared 4x4 fixed-point `mat_mul` unit inside the vertex shader to build the combined transform MVP = proj x view x model.
- Uses two back-to-back multiply jobs and registers the result.
- Holds MVP stable and flags it valid for the downstream `mat_vec_mul` vertex stage.
- Owns `mat_mul`'s request handshake; no other requester drives it while a job is in flight.

---
 rtl/render_pkg.sv | 24 ++
 rtl/timeout_counter.sv | 27 ++
 rtl/mvp_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/render_pkg.sv
// Shared rendering types: fixed-point 4x4 matrix type and the MVP sequencer state encoding.
package render_pkg;

  localparam int unsigned MAT_DATAWIDTH = 18;
  localparam int unsigned MAT_FRACBITS  = 12;
  localparam int unsigned FIX_ONE       = 1 << MAT_FRACBITS;

  // Element [r][c] is row r, column c.
  typedef logic signed [3:0][3:0][MAT_DATAWIDTH-1:0] mat4_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssueVp,
    StWaitVp,
    StIssueMvp,
    StWaitMvp,
    StDone
  } mvp_state_t;

  function automatic logic is_wait_state(input mvp_state_t s);
    return (s == StWaitVp) || (s == StWaitMvp);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Counts cycles while enabled; flags expiry on the last allowed cycle of a wait window.
module timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCount = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + CntW'(1);
    end
  end

  assign expired = enable && (count_q == LastCount);

endmodule

// File: rtl/mvp_sequencer.sv
// Drives the shared mat_mul unit twice to form MVP = proj x view x model and holds the result
// stable, with a valid level, for the downstream vertex stage.
module mvp_sequencer
  import render_pkg::*;
#(
  parameter int unsigned DATAWIDTH      = MAT_DATAWIDTH,
  parameter int unsigned FRACBITS       = MAT_FRACBITS,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic signed [3:0][3:0][DATAWIDTH-1:0] model_mat,
  input  logic signed [3:0][3:0][DATAWIDTH-1:0] view_mat,
  input  logic signed [3:0][3:0][DATAWIDTH-1:0] proj_mat,
  input  logic                                 i_mat_dv,
  output logic                                 o_ready,
  output logic signed [3:0][3:0][DATAWIDTH-1:0] o_mm_a,
  output logic signed [3:0][3:0][DATAWIDTH-1:0] o_mm_b,
  output logic                                 o_mm_dv,
  input  logic signed [3:0][3:0][DATAWIDTH-1:0] i_mm_c,
  input  logic                                 i_mm_dv,
  input  logic                                 i_mm_ready,
  output logic signed [3:0][3:0][DATAWIDTH-1:0] o_mvp,
  output logic                                 o_mvp_dv,
  output logic                                 o_mvp_valid,
  output logic                                 o_err
);

  // Fixed-point format is carried for documentation only; reject nonsensical formats.
  if (FRACBITS >= DATAWIDTH) begin : g_bad_fracbits
    $error("mvp_sequencer: FRACBITS must be smaller than DATAWIDTH");
  end

  mvp_state_t state_q;
  logic signed [3:0][3:0][DATAWIDTH-1:0] model_q;
  logic timeout_hit;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (!is_wait_state(state_q)),
    .enable (is_wait_state(state_q)),
    .expired(timeout_hit)
  );

  // Issue fires in the same cycle mat_mul reports ready, so no job start is ever lost or doubled.
  assign o_mm_dv = ((state_q == StIssueVp) || (state_q == StIssueMvp)) && i_mm_ready;

  // o_mm_a/o_mm_b double as the proj/view copies and later as the VP scratch + model copy,
  // so operands stay frozen from issue until the matching result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      model_q     <= '0;
      o_mm_a      <= '0;
      o_mm_b      <= '0;
      o_mvp       <= '0;
      o_ready     <= 1'b0;
      o_mvp_dv    <= 1'b0;
      o_mvp_valid <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_mvp_dv <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_mat_dv && o_ready) begin
            o_mm_a      <= proj_mat;
            o_mm_b      <= view_mat;
            model_q     <= model_mat;
            o_mvp_valid <= 1'b0;
            o_err       <= 1'b0;
            o_ready     <= 1'b0;
            state_q     <= StIssueVp;
          end else begin
            o_ready <= 1'b1;
          end
        end
        StIssueVp: begin
          if (i_mm_ready) begin
            state_q <= StWaitVp;
          end
        end
        StWaitVp: begin
          if (i_mm_dv) begin
            o_mm_a  <= i_mm_c;
            o_mm_b  <= model_q;
            state_q <= StIssueMvp;
          end else if (timeout_hit) begin
            o_err   <= 1'b1;
            o_ready <= 1'b1;
            state_q <= StIdle;
          end
        end
        StIssueMvp: begin
          if (i_mm_ready) begin
            state_q <= StWaitMvp;
          end
        end
        StWaitMvp: begin
          if (i_mm_dv) begin
            o_mvp   <= i_mm_c;
            state_q <= StDone;
          end else if (timeout_hit) begin
            o_err   <= 1'b1;
            o_ready <= 1'b1;
            state_q <= StIdle;
          end
        end
        StDone: begin
          o_mvp_dv    <= 1'b1;
          o_mvp_valid <= 1'b1;
          o_ready     <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
